// File: rtl/ahb_apb3_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: FSM states, AHB response
// and transfer codes, and a constant-evaluable ceil(log2) helper.
package ahb_apb3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; expire_o fires in the cycle whose low
// PREADY would be the TIMEOUT-th one. TIMEOUT of 0 never expires.
module apb_wait_timer
  import ahb_apb3_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam int TW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [TW:0] LIMIT = (TW + 1)'(TIMEOUT);

  logic [TW-1:0] count_q, count_d;
  logic [TW:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{TW{1'b0}}, 1'b1};
  assign expire_o  = (TIMEOUT != 0) && count_en_i && (count_inc == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && !expire_o) begin
      count_d = count_inc[TW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ahb_apb3_bridge_mslv.sv
// AHB-Lite slave to APB3 master bridge with a one-hot slot decoder, ERROR
// response for unmapped slots / PSLVERR, and a PREADY wait-timeout abort.
module ahb_apb3_bridge_mslv
  import ahb_apb3_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLOT_BITS  = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                             HCLK,
  input  logic                             HRESETN,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  input  logic                             HREADY,
  output logic                             HREADYOUT,
  output logic [1:0]                       HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  output logic                             TIMEOUT_FLAG
);

  localparam int IDXW = (clog2(NUM_SLAVES) < 1) ? 1 : clog2(NUM_SLAVES);
  localparam logic [IDXW:0] NUM_SLV = (IDXW + 1)'(NUM_SLAVES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [IDXW-1:0]       idx_q, idx_d, idx_in;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d, sel_rdata;
  logic                  hreadyout_q, hreadyout_d, tflag_q, tflag_d;
  logic [1:0]            hresp_q, hresp_d;
  logic                  valid, mapped_in, sel_ready, sel_err, expire;
  logic                  apb_active, timer_clear, timer_en;

  assign valid      = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign idx_in     = HADDR[SLOT_BITS+IDXW-1:SLOT_BITS];
  assign mapped_in  = {1'b0, idx_in} < NUM_SLV;
  assign apb_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  // Only the selected slave's PREADY/PSLVERR/PRDATA reach the FSM.
  always_comb begin
    PSEL      = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDXW'(k)) begin
        PSEL[k]   = apb_active;
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
        sel_rdata = PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    tflag_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (valid) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          idx_d   = idx_in;
          if (!mapped_in)  state_d = ST_ERR1;
          else if (HWRITE) state_d = ST_WDATA;
          else             state_d = ST_SETUP;
        end
      end
      ST_WDATA: begin
        pwdata_d = HWDATA;
        state_d  = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = ST_ERR1;
          end else begin
            if (!write_q) hrdata_d = sel_rdata;
            state_d = ST_IDLE;
          end
        end else if (expire) begin
          tflag_d = 1'b1;
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // AHB response outputs are a registered decode of the upcoming state.
  assign hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
  assign hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign timer_clear = (state_d == ST_SETUP);
  assign timer_en    = (state_q == ST_ACCESS) && !sel_ready;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i      (HCLK),
    .rst_ni     (HRESETN),
    .clear_i    (timer_clear),
    .count_en_i (timer_en),
    .expire_o   (expire)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      tflag_q     <= tflag_d;
    end
  end

  assign HREADYOUT    = hreadyout_q;
  assign HRESP        = hresp_q;
  assign HRDATA       = hrdata_q;
  assign PADDR        = addr_q;
  assign PWRITE       = write_q;
  assign PWDATA       = pwdata_q;
  assign PENABLE      = (state_q == ST_ACCESS);
  assign TIMEOUT_FLAG = tflag_q;

endmodule

// File: tb/tb_ahb_apb3_bridge_mslv.sv
// Directed bench: each transfer is expanded into the per-cycle outputs the
// protocol demands, queued, and compared at every falling edge.
module tb_ahb_apb3_bridge_mslv;
  import ahb_apb3_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 5;
  localparam int TO = 4;

  logic             HCLK, HRESETN, HSEL, HWRITE, HREADY;
  logic [AW-1:0]    HADDR, PADDR;
  logic [1:0]       HTRANS, HRESP;
  logic [DW-1:0]    HWDATA, HRDATA, PWDATA;
  logic             HREADYOUT, PENABLE, PWRITE, TIMEOUT_FLAG;
  logic [NS-1:0]    PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  ahb_apb3_bridge_mslv #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLOT_BITS(12), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  typedef struct packed {
    logic          hready;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic [NS-1:0] psel;
    logic          penable;
    logic          tflag;
    logic          chk_addr;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          chk_wdata;
    logic [DW-1:0] pwdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          pend;
  exp_t          ce;
  logic [DW-1:0] model_hrdata;
  int            total = 0;
  int            bad   = 0;
  int            cyc_n = 0;

  // ---------------- clock ----------------
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, req);
    end
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("HREADYOUT", 64'(HREADYOUT), 64'(ce.hready));
      chk("HRESP", 64'(HRESP), 64'(ce.hresp));
      chk("HRDATA", 64'(HRDATA), 64'(ce.hrdata));
      chk("PSEL", 64'(PSEL), 64'(ce.psel));
      chk("PENABLE", 64'(PENABLE), 64'(ce.penable));
      chk("TIMEOUT_FLAG", 64'(TIMEOUT_FLAG), 64'(ce.tflag));
      if (ce.chk_addr) begin
        chk("PADDR", 64'(PADDR), 64'(ce.paddr));
        chk("PWRITE", 64'(PWRITE), 64'(ce.pwrite));
      end
      if (ce.chk_wdata) chk("PWDATA", 64'(PWDATA), 64'(ce.pwdata));
    end
    cyc_n++;
  end

  // ---------------- expectation builders ----------------
  function automatic exp_t busy_rec();
    exp_t e;
    e = '0;
    e.hrdata = model_hrdata;
    return e;
  endfunction

  function automatic exp_t idle_rec();
    exp_t e;
    e = busy_rec();
    e.hready = 1'b1;
    return e;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e = '0;
    e.hready    = 1'b1;
    e.chk_addr  = 1'b1;
    e.chk_wdata = 1'b1;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic noise();
    int m;
    m      = $urandom_range(0, 2);
    HADDR  = $urandom;
    HWRITE = 1'($urandom_range(0, 1));
    HWDATA = $urandom;
    HREADY = 1'b1;
    case (m)
      0:       begin HSEL = 1'b0; HTRANS = 2'($urandom_range(0, 3)); end
      1:       begin HSEL = 1'b1; HTRANS = ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE; end
      default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADY = 1'b0; end
    endcase
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    for (int k = 0; k < NS; k++) PRDATA[k*DW +: DW] = $urandom;
  endtask

  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  task automatic take_rest(output exp_t e);
    e    = pend;
    pend = idle_rec();
  endtask

  task automatic idle_cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      noise();
      take_rest(e);
      cyc(e);
    end
  endtask

  task automatic err_resp(input bit tf);
    exp_t e;
    noise();
    e       = busy_rec();
    e.hresp = HRESP_ERROR;
    e.tflag = tf;
    cyc(e);
    pend       = idle_rec();
    pend.hresp = HRESP_ERROR;
  endtask

  // waits < 0: selected slave never raises PREADY. rst_after >= 0: pulse
  // HRESETN low in that ACCESS cycle instead of completing.
  task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wd,
                      input int waits, input bit serr, input logic [DW-1:0] rd,
                      input int rst_after);
    exp_t e;
    int   idx;
    int   k;
    bit   rdy;
    idx = int'((addr >> 12) & 32'h7);
    noise();
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADY = 1'b1; HADDR = addr; HWRITE = wr;
    take_rest(e);
    cyc(e);
    if (idx >= NS) begin
      err_resp(1'b0);
      return;
    end
    if (wr) begin
      noise();
      HWDATA = wd;
      cyc(busy_rec());
    end
    noise();
    e           = busy_rec();
    e.psel      = NS'(1 << idx);
    e.chk_addr  = 1'b1;
    e.paddr     = addr;
    e.pwrite    = wr;
    e.chk_wdata = wr;
    e.pwdata    = wd;
    cyc(e);
    k   = 0;
    rdy = 1'b0;
    forever begin
      if (k == rst_after) begin
        HRESETN = 1'b0;
        model_hrdata = '0;
        noise();
        cyc(reset_rec());
        noise();
        cyc(reset_rec());
        HRESETN = 1'b1;
        pend = idle_rec();
        return;
      end
      rdy = (waits >= 0) && (k == waits);
      noise();
      PREADY[idx]         = rdy;
      PSLVERR[idx]        = rdy ? serr : 1'($urandom_range(0, 1));
      PRDATA[idx*DW +: DW] = rd;
      e.penable = 1'b1;
      cyc(e);
      if (rdy) break;
      if (waits < 0 && k == TO - 1) break;
      k++;
    end
    if (!rdy) begin
      err_resp(1'b1);
      return;
    end
    if (serr) begin
      err_resp(1'b0);
      return;
    end
    if (!wr) model_hrdata = rd;
    pend = idle_rec();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    HRESETN      = 1'b0;
    model_hrdata = '0;
    noise();
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      noise();
      cyc(reset_rec());
    end
    HRESETN = 1'b1;
    pend = idle_rec();
    idle_cyc(2);

    // zero-wait read of slave 2
    xfer(32'h0000_2010, 1'b0, '0, 0, 1'b0, 32'hCAFE_F00D, -1);
    #1;
    chk("lit read HRDATA", 64'(HRDATA), 64'h0000_0000_CAFE_F00D);
    chk("lit read HREADYOUT", 64'(HREADYOUT), 64'd1);
    chk("lit read HRESP", 64'(HRESP), 64'd0);
    idle_cyc(2);

    // write with three PREADY-low ACCESS cycles
    xfer(32'h0000_1004, 1'b1, 32'hA5A5_A5A5, 3, 1'b0, '0, -1);
    idle_cyc(1);

    // back-to-back write then read
    xfer(32'h0000_3008, 1'b1, 32'h0BAD_BEEF, 0, 1'b0, '0, -1);
    xfer(32'h0000_4008, 1'b0, '0, 1, 1'b0, 32'h1234_5678, -1);
    idle_cyc(1);

    // unmapped slot, then a PSLVERR read taken straight out of ERR2
    xfer(32'h0000_5000, 1'b0, '0, 0, 1'b0, '0, -1);
    #1;
    chk("lit unmapped HRESP", 64'(HRESP), 64'd1);
    chk("lit unmapped HREADYOUT", 64'(HREADYOUT), 64'd1);
    chk("lit unmapped PSEL", 64'(PSEL), 64'd0);
    xfer(32'h0000_0000, 1'b0, '0, 0, 1'b1, 32'hDEAD_DEAD, -1);
    #1;
    chk("lit slverr HRDATA", 64'(HRDATA), 64'h0000_0000_1234_5678);
    idle_cyc(1);

    // timeout on slave 3, then an unmapped write from ERR2
    xfer(32'h0000_3000, 1'b1, 32'h5555_AAAA, -1, 1'b0, '0, -1);
    #1;
    chk("lit timeout HRESP", 64'(HRESP), 64'd1);
    xfer(32'h0000_7000, 1'b1, 32'h1111_2222, 0, 1'b0, '0, -1);
    idle_cyc(2);

    // reset pulsed during ACCESS
    xfer(32'h0000_3004, 1'b0, '0, -1, 1'b0, 32'h7777_7777, 2);
    #1;
    chk("lit reset HRDATA", 64'(HRDATA), 64'd0);
    chk("lit reset PADDR", 64'(PADDR), 64'd0);
    xfer(32'h0000_2FFC, 1'b0, '0, 2, 1'b0, 32'h600D_F00D, -1);
    idle_cyc(3);

    @(negedge HCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
